// File: rtl/sub_layer_lut_seq.sv
// sub_layer_lut_seq: time-multiplexed programmable S-box layer sweeping LANES columns per cycle
module sub_layer_lut_seq #(
    parameter int WORD_W        = 64,
    parameter int SBOX_W        = 5,
    parameter int LANES         = 16,
    parameter int DEFAULT_ASCON = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [SBOX_W*WORD_W-1:0] state_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [SBOX_W*WORD_W-1:0] state_o,
    input  logic                     tbl_we_i,
    output logic                     tbl_ready_o,
    input  logic [SBOX_W-1:0]        tbl_addr_i,
    input  logic [SBOX_W-1:0]        tbl_data_i,
    output logic                     busy_o
);
    localparam int R     = WORD_W / LANES;
    localparam int CW    = (R > 1) ? $clog2(R) : 1;
    localparam int DEPTH = 1 << SBOX_W;
    localparam logic [4:0] ASCON [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    r_state, w_next;
    logic [CW-1:0]             r_cnt;
    logic [SBOX_W*WORD_W-1:0]  r_in, r_out, w_next_out;
    logic [SBOX_W-1:0]         r_tbl [DEPTH];
    logic [SBOX_W-1:0]         w_addr [LANES];
    logic [SBOX_W-1:0]         w_res [LANES];
    logic                      w_last, w_accept, w_wr;

    function automatic logic [SBOX_W-1:0] def_entry(input int i);
        logic [31:0] w_i;
        w_i = i;
        return (DEFAULT_ASCON != 0 && SBOX_W == 5) ? SBOX_W'(ASCON[w_i[4:0]]) : SBOX_W'(i);
    endfunction

    assign w_last   = r_cnt == CW'(R - 1);
    assign w_accept = r_state == IDLE && in_valid_i && !tbl_we_i;
    assign w_wr     = r_state == IDLE && tbl_we_i;
    assign state_o  = r_out;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // FSM next state and handshake outputs; table writes win over input accept in IDLE
    always_comb begin
        w_next      = r_state;
        in_ready_o  = 1'b0;
        tbl_ready_o = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready_o  = !tbl_we_i;
                tbl_ready_o = 1'b1;
                if (in_valid_i && !tbl_we_i) w_next = RUN;
            end
            RUN: begin
                busy_o = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Gather the current column group into per-lane addresses, x0 as address MSB
    always_comb begin
        for (int l = 0; l < LANES; l++) w_addr[l] = '0;
        for (int g = 0; g < R; g++)
            for (int l = 0; l < LANES; l++)
                for (int k = 0; k < SBOX_W; k++)
                    if (r_cnt == CW'(g)) w_addr[l][SBOX_W-1-k] = r_in[k*WORD_W + g*LANES + l];
    end

    // Shared table lookup, one per lane
    always_comb begin
        for (int l = 0; l < LANES; l++) w_res[l] = r_tbl[w_addr[l]];
    end

    // Scatter lane results back into the current column group only
    always_comb begin
        w_next_out = r_out;
        for (int g = 0; g < R; g++)
            for (int l = 0; l < LANES; l++)
                for (int k = 0; k < SBOX_W; k++)
                    if (r_cnt == CW'(g)) w_next_out[k*WORD_W + g*LANES + l] = w_res[l][SBOX_W-1-k];
    end

    // Datapath: table programming, input capture, group-by-group result update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_in  <= '0;
            r_out <= '0;
            for (int i = 0; i < DEPTH; i++) r_tbl[i] <= def_entry(i);
        end else begin
            if (w_wr) r_tbl[tbl_addr_i] <= tbl_data_i;
            if (w_accept) begin
                r_in  <= state_i;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_out <= w_next_out;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sub_layer_lut_seq.sv
// tb_sub_layer_lut_seq: directed self-checking bench for the sequential S-box layer
module tb_sub_layer_lut_seq;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZERO = 64'h0;

    logic         clk, rst;
    logic         in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [319:0] state_i, state_o;
    logic         tbl_we_i, tbl_ready_o, busy_o;
    logic [4:0]   tbl_addr_i, tbl_data_i;
    int           n_checks = 0;
    int           n_fail = 0;

    sub_layer_lut_seq dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .state_i(state_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .state_o(state_o),
        .tbl_we_i(tbl_we_i), .tbl_ready_o(tbl_ready_o),
        .tbl_addr_i(tbl_addr_i), .tbl_data_i(tbl_data_i), .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [319:0] pk(input logic [63:0] x0, x1, x2, x3, x4);
        return {x4, x3, x2, x1, x0};
    endfunction

    // Accept s, wait (bounded) for out_valid_o, grab result, then release it
    task automatic run_state(input logic [319:0] s, output logic [319:0] res, output int edges);
        in_valid_i = 1'b1;
        state_i    = s;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        edges = 0;
        while (!out_valid_o && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        res = state_o;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
        n_checks++; if (state_o !== 320'h0) begin n_fail++; $display("FAIL reset_state: got %h want 0", state_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        n_checks++; if (tbl_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_tbl_ready: got %b want 1", tbl_ready_o); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_zero();
        logic [319:0] res, exp;
        int e;
        exp = pk(ZERO, ZERO, ONES, ZERO, ZERO);
        run_state(320'h0, res, e);
        n_checks++; if (e !== 4) begin n_fail++; $display("FAIL zero_latency: got %0d want 4", e); end
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL zero_result: got %h want %h", res, exp); end
    endtask

    task automatic test_ones();
        logic [319:0] res, exp;
        int e;
        exp = pk(ONES, ZERO, ONES, ONES, ONES);
        run_state(pk(ONES, ONES, ONES, ONES, ONES), res, e);
        n_checks++; if (e !== 4) begin n_fail++; $display("FAIL ones_latency: got %0d want 4", e); end
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL ones_result: got %h want %h", res, exp); end
    endtask

    task automatic test_mixed();
        logic [319:0] res, exp;
        int e;
        exp = pk(64'h1, 64'h1, ONES, 64'h1, ZERO);
        run_state(pk(64'h1, ZERO, ZERO, ZERO, ZERO), res, e);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL mixed_result: got %h want %h", res, exp); end
    endtask

    task automatic test_columns();
        logic [319:0] res, exp;
        int e;
        exp = pk(64'h0000_0000_0010_0000, 64'h8000_0000_0010_0000, 64'h7FFF_FFFF_FFEF_FFFF,
                 64'h8000_0000_0010_0000, 64'h8000_0000_0010_0000);
        run_state(pk(ZERO, 64'h0000_0000_0010_0000, ZERO, ZERO, 64'h8000_0000_0000_0000), res, e);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL columns_result: got %h want %h", res, exp); end
    endtask

    task automatic test_backpressure();
        logic [319:0] exp;
        int e;
        exp = pk(64'h1, 64'h1, ONES, 64'h1, ZERO);
        in_valid_i = 1'b1;
        state_i    = pk(64'h1, ZERO, ZERO, ZERO, ZERO);
        @(posedge clk); #1;
        state_i = pk(ONES, ONES, ONES, ONES, ONES);
        e = 0;
        while (!out_valid_o && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
        n_checks++; if (e !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d want 4", e); end
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", c, out_valid_o); end
            n_checks++; if (state_o !== exp) begin n_fail++; $display("FAIL bp_state_hold[%0d]: got %h want %h", c, state_o, exp); end
            n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready_o); end
            @(posedge clk); #1;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b want 0", busy_o); end
        n_checks++; if (state_o !== exp) begin n_fail++; $display("FAIL bp_idle_hold: got %h want %h", state_o, exp); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready: got %b want 1", in_ready_o); end
    endtask

    task automatic test_priority();
        logic [319:0] res, exp;
        int e;
        tbl_we_i   = 1'b1;
        tbl_addr_i = 5'd1;
        tbl_data_i = 5'h1F;
        in_valid_i = 1'b1;
        state_i    = 320'h0;
        #1;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL prio_in_ready: got %b want 0", in_ready_o); end
        n_checks++; if (tbl_ready_o !== 1'b1) begin n_fail++; $display("FAIL prio_tbl_ready: got %b want 1", tbl_ready_o); end
        @(posedge clk); #1;
        tbl_we_i   = 1'b0;
        in_valid_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL prio_no_accept: got busy %b want 0", busy_o); end
        exp = pk(64'h1, 64'h1, ONES, 64'h1, 64'h1);
        run_state(pk(ZERO, ZERO, ZERO, ZERO, 64'h1), res, e);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL prio_written_entry: got %h want %h", res, exp); end
    endtask

    task automatic test_reprogram();
        logic [319:0] res, exp;
        int e;
        exp = pk(ONES, ONES, ONES, ONES, ONES);
        tbl_we_i   = 1'b1;
        tbl_addr_i = 5'd0;
        tbl_data_i = 5'h1F;
        @(posedge clk); #1;
        tbl_we_i = 1'b0;
        run_state(320'h0, res, e);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL reprog_result: got %h want %h", res, exp); end
        in_valid_i = 1'b1;
        state_i    = 320'h0;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        tbl_we_i   = 1'b1;
        tbl_data_i = 5'h04;
        #1;
        n_checks++; if (tbl_ready_o !== 1'b0) begin n_fail++; $display("FAIL run_tbl_ready: got %b want 0", tbl_ready_o); end
        e = 0;
        while (!out_valid_o && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
        n_checks++; if (tbl_ready_o !== 1'b0) begin n_fail++; $display("FAIL done_tbl_ready: got %b want 0", tbl_ready_o); end
        tbl_we_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        run_state(320'h0, res, e);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL run_write_ignored: got %h want %h", res, exp); end
    endtask

    task automatic test_reset_mid_run();
        logic [319:0] res, exp;
        int e;
        in_valid_i = 1'b1;
        state_i    = 320'h0;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
        n_checks++; if (state_o !== 320'h0) begin n_fail++; $display("FAIL midrst_state: got %h want 0", state_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp = pk(ZERO, ZERO, ONES, ZERO, ZERO);
        run_state(320'h0, res, e);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL midrst_table0: got %h want %h", res, exp); end
        exp = pk(64'h0000_0000_0010_0000, 64'h8000_0000_0010_0000, 64'h7FFF_FFFF_FFEF_FFFF,
                 64'h8000_0000_0010_0000, 64'h8000_0000_0010_0000);
        run_state(pk(ZERO, 64'h0000_0000_0010_0000, ZERO, ZERO, 64'h8000_0000_0000_0000), res, e);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL midrst_table1: got %h want %h", res, exp); end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        state_i     = '0;
        tbl_we_i    = 1'b0;
        tbl_addr_i  = '0;
        tbl_data_i  = '0;
        test_reset();
        test_zero();
        test_ones();
        test_mixed();
        test_columns();
        test_backpressure();
        test_priority();
        test_reprogram();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
